// File: rtl/dav_rfd_receiver_pkg.sv
// Shared types and defaults for the dav_/rfd receiver slice.
package dav_rfd_receiver_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_DEPTH = 4;

   typedef enum logic [1:0] {
      S_SYNC = 2'd0,
      S_IDLE = 2'd1,
      S_ACK  = 2'd2
   } rx_state_t;

endpackage

// File: rtl/dav_rfd_receiver_fifo.sv
// First-word-fall-through FIFO; occupancy is kept in its own register.
module sync_fifo_fwft
   import dav_rfd_receiver_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
)
(
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is not reset; an empty FIFO never exposes stale words as valid.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/dav_rfd_receiver.sv
// Consumer end of the dav_/rfd handshake feeding a FWFT FIFO.
// Optional DAV_CHECK_EN adds a sticky check that q_in stays stable while dav_ is low.
module dav_rfd_receiver
   import dav_rfd_receiver_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
)
(
   input  logic                       clock,
   input  logic                       reset,
   input  logic [WIDTH-1:0]           q_in,
   input  logic                       dav_,
   output logic                       rfd,
   output logic [WIDTH-1:0]           out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       proto_err,
   output rx_state_t                  dbg_state
);

   localparam int CW = $clog2(DEPTH+1);

   rx_state_t     state;
   rx_state_t     state_next;
   logic          rfd_next;
   logic          push;
   logic          pop;
   logic          full;
   logic          empty;
   logic [CW-1:0] count_after_pop;
   logic          space;

   // Downstream: a word moves on every rising edge where out_valid && out_ready;
   // out_valid never depends on out_ready, and out_data is stable while out_valid waits.
   assign out_valid       = !empty;
   assign pop             = out_valid && out_ready;
   assign count_after_pop = count - CW'(pop);
   assign space           = (count_after_pop < CW'(DEPTH));
   assign dbg_state       = state;

   sync_fifo_fwft #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push    (push),
      .wr_data (q_in),
      .pop     (pop),
      .rd_data (out_data),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= S_SYNC;
         rfd   <= 1'b0;
      end else begin
         state <= state_next;
         rfd   <= rfd_next;
      end
   end

   // Any push also clears rfd, so space only needs to account for a pop.
   always_comb begin
      state_next = state;
      rfd_next   = rfd;
      push       = 1'b0;
      case (state)
         S_SYNC: begin
            rfd_next = 1'b0;
            if (dav_) begin
               state_next = S_IDLE;
               rfd_next   = space;
            end
         end
         S_IDLE: begin
            rfd_next = space;
            if (!dav_ && rfd) begin
               push       = 1'b1;
               rfd_next   = 1'b0;
               state_next = S_ACK;
            end
         end
         S_ACK: begin
            rfd_next = 1'b0;
            if (dav_) begin
               state_next = S_IDLE;
               rfd_next   = space;
            end
         end
         default: begin
            state_next = S_SYNC;
            rfd_next   = 1'b0;
         end
      endcase
   end

`ifdef DAV_CHECK_EN
   logic [WIDTH-1:0] shadow;

   always_ff @(posedge clock) begin
      if (reset) begin
         shadow    <= '0;
         proto_err <= 1'b0;
      end else begin
         if (push) shadow <= q_in;
         if (state == S_ACK && !dav_ && q_in != shadow) proto_err <= 1'b1;
      end
   end
`else
   assign proto_err = 1'b0;
`endif

   logic unused_full;
   assign unused_full = full;

endmodule

// File: doc/dav_rfd_receiver.md
Name: dav_rfd_receiver

Overview:
- Consumer end of the team's dav_/rfd output handshake.
- Captures each word a producer (e.g. the soc/eoc conversion-and-compute units) presents on its q bus with dav_ low, and acknowledges it by dropping rfd.
- Buffers captured words in a small first-word-fall-through FIFO.
- Hands words to downstream logic over a valid/ready interface, so a slow consumer back-pressures the producer via rfd.

Parameters:
- WIDTH, 32, data word width (matches the producer q bus).
- DEPTH, 4, FIFO entries; power of two, at least 2.

Ports:
- clock  in  1  system clock, all logic on the rising edge.
- reset  in  1  synchronous, active-high reset. No trailing underscore: the codebase reserves the trailing underscore for active-low signals.
- q_in  in  WIDTH  producer data, valid while dav_==0.
- dav_  in  1  producer data-available, active low.
- rfd  out  1  ready-for-data to the producer, registered.
- out_data  out  WIDTH  FIFO head word, combinational from storage.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  downstream accepts head this cycle.
- count  out  $clog2(DEPTH+1)  current occupancy.
- proto_err  out  1  sticky protocol error; 0 when DAV_CHECK_EN is undefined.

Behaviour:
- Reset values: rfd=0, FIFO empty, count=0, out_valid=0, proto_err=0, state S_SYNC.
- S_SYNC: rfd=0. On dav_==1, go to S_IDLE and set rfd<=(count<DEPTH). Purpose: a stale dav_ low at reset release is never captured.
- S_IDLE: rfd reflects space (rfd<=(count_next<DEPTH)). On dav_==0 with rfd==1: push q_in, rfd<=0, go to S_ACK. dav_==0 with rfd==0 (full) is ignored, and the block stays in S_IDLE.
- S_ACK: rfd held 0. On dav_==1, go to S_IDLE and set rfd<=(count_next<DEPTH). Otherwise stay.
- Capture latency: q_in is sampled at the first rising edge where dav_==0 and rfd==1. rfd falls one clock later, i.e. registered.
- Exactly one push per dav_ low pulse, regardless of pulse length.
- Pop: on out_valid && out_ready, the head is removed. out_data shows the next word in the following cycle.
- Push and pop in the same cycle: count unchanged. When full, a pop in cycle N makes rfd=1 at edge N+1.
- count saturates logically at DEPTH. Read/write pointers are log2(DEPTH) bits and wrap naturally. count is a separate register, not derived from the pointers.
- Pop while empty: ignored, no pointer movement.
- Reset mid-transfer (any state): FIFO is flushed, state goes to S_SYNC, rfd=0. The word in flight is lost, and the producer must complete its dav_ high phase first.

Optional Feature:
- Macro: DAV_CHECK_EN.
- Defined: in S_ACK, while dav_==0, compare q_in against the word just captured (a shadow register). On any mismatch, proto_err<=1. proto_err is sticky until reset.
- Undefined: no shadow register, and proto_err is tied 0.

Decomposition:
- Shared package: state encoding localparams S_SYNC/S_IDLE/S_ACK, and the default WIDTH/DEPTH constants.
- One natural sub-module, sync_fifo_fwft (WIDTH, DEPTH; push/pop/full/empty/count, head output).
- dav_rfd_receiver itself contains only the handshake FSM, the rfd register and the optional checker.

Test Plan:
- Reset released with dav_=0, q_in=32'hDEAD_BEEF; dav_ rises after 5 cycles -> no push, count=0, rfd=0 until one cycle after dav_==1, then rfd=1.
- Single transfer of q_in=32'h0003_FC01 with dav_ low for 3 cycles, out_ready=0 -> exactly one push, count=1, out_data=32'h0003_FC01, rfd 0 during S_ACK and 1 after dav_ rises.
- Five transfers (values 1..5) with out_ready=0, DEPTH=4 -> count=4, rfd stays 0 after the fourth acknowledge, fifth word not captured. Then one pop -> rfd=1 next edge, word 5 captured, FIFO order 2,3,4,5.
- Continuous traffic with out_ready toggling every cycle, 20 words 0..19 -> downstream sees 0..19 in order with no loss or duplication; simultaneous push/pop leaves count unchanged.
- Reset asserted in S_ACK with count=2 -> count=0, out_valid=0, rfd=0 the cycle after; normal capture resumes after dav_ goes 1 then 0.
- DAV_CHECK_EN defined: q_in changes from 32'h10 to 32'h11 while dav_ is still low in S_ACK -> proto_err=1 and held through later clean transfers until reset.
